// File: rtl/localbus_arbiter_pkg.sv
// Shared types for the two-master LocalBus arbiter: FSM states, master ids, read tags.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package localbus_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } arb_state_t;

    typedef enum logic {
        LB_M0 = 1'b0,
        LB_M1 = 1'b1
    } master_id_t;

    localparam logic [2:0] LB_WE_READ = 3'b000;

    // One slot of the read-return pipe: which master is owed the data.
    typedef struct packed {
        logic       vld;
        master_id_t id;
    } rd_tag_t;

    // Beat counter width; a one-beat burst still needs a one-bit counter.
    function automatic int cnt_width(input int max_burst);
        return (max_burst > 1) ? $clog2(max_burst) : 1;
    endfunction

endpackage

// File: rtl/localbus_arbiter_if.sv
// Bundle of both masters' req/gnt/read-return signals plus the shared LocalBus drive.
// Latency: none (wiring only).
// Backpressure: req held by a master until it sees gnt; the bus side has no stall.
interface localbus_arbiter_if #(
    parameter int XLEN = 32
);
    logic            m0_req;
    logic [XLEN-1:0] m0_addr;
    logic [XLEN-1:0] m0_qin;
    logic [2:0]      m0_we;
    logic            m0_gnt;
    logic            m0_rvalid;
    logic [XLEN-1:0] m0_rdata;

    logic            m1_req;
    logic [XLEN-1:0] m1_addr;
    logic [XLEN-1:0] m1_qin;
    logic [2:0]      m1_we;
    logic            m1_gnt;
    logic            m1_rvalid;
    logic [XLEN-1:0] m1_rdata;

    logic [XLEN-1:0] lb_addr;
    logic [XLEN-1:0] lb_qin;
    logic [2:0]      lb_we;
    logic [XLEN-1:0] lb_qout;

    // Arbiter side.
    modport slave (
        input  m0_req, m0_addr, m0_qin, m0_we,
        output m0_gnt, m0_rvalid, m0_rdata,
        input  m1_req, m1_addr, m1_qin, m1_we,
        output m1_gnt, m1_rvalid, m1_rdata,
        output lb_addr, lb_qin, lb_we,
        input  lb_qout
    );

    // Environment side: the two masters and the LocalBus itself.
    modport master (
        output m0_req, m0_addr, m0_qin, m0_we,
        input  m0_gnt, m0_rvalid, m0_rdata,
        output m1_req, m1_addr, m1_qin, m1_we,
        input  m1_gnt, m1_rvalid, m1_rdata,
        input  lb_addr, lb_qin, lb_we,
        output lb_qout
    );

endinterface

// File: rtl/localbus_arbiter_rd_tracker.sv
// Remembers which master issued each accepted read and steers lb_qout back to it.
// Latency: rvalid/rdata appear RD_LATENCY cycles after the accepted read beat.
// Backpressure: none; accepts one read per cycle, masters must take data when rvalid pulses.
module localbus_arbiter_rd_tracker
    import localbus_arbiter_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push_vld,
    input  master_id_t      push_id,
    input  logic [XLEN-1:0] lb_qout,
    output logic            m0_rvalid,
    output logic [XLEN-1:0] m0_rdata,
    output logic            m1_rvalid,
    output logic [XLEN-1:0] m1_rdata
);

    rd_tag_t pipe [RD_LATENCY];
    rd_tag_t tail;

    // Shift the issuer tag along with the RAM's read latency; reset drops reads in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RD_LATENCY; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0].vld <= push_vld;
            pipe[0].id  <= push_id;
            for (int i = 1; i < RD_LATENCY; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    // Demux the returning word to the master that asked for it; zero when not valid.
    always_comb begin
        tail      = pipe[RD_LATENCY-1];
        m0_rvalid = tail.vld && (tail.id == LB_M0);
        m1_rvalid = tail.vld && (tail.id == LB_M1);
        m0_rdata  = m0_rvalid ? lb_qout : '0;
        m1_rdata  = m1_rvalid ? lb_qout : '0;
    end

endmodule

// File: rtl/localbus_arbiter.sv
// Two-master LocalBus arbiter (CPU data port M0, DMA/boot M1), round-robin with burst limit.
// Latency: gnt one cycle after req; beats pass through combinationally; reads return after RD_LATENCY.
// Backpressure: a master waits with req held until gnt; optional LOCALBUS_ARB_FIXED_PRIO_EN favours M0.
module localbus_arbiter
    import localbus_arbiter_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int MAX_BURST  = 8,
    parameter int RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    localbus_arbiter_if.slave bus
);

`ifdef LOCALBUS_ARB_FIXED_PRIO_EN
    localparam bit FIXED_PRIO = 1'b1;
`else
    localparam bit FIXED_PRIO = 1'b0;
`endif

    localparam int             CNT_W    = cnt_width(MAX_BURST);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

    arb_state_t       state;
    arb_state_t       state_nxt;
    master_id_t       last_owner;
    logic [CNT_W-1:0] beat_cnt;
    logic             gnt0;
    logic             gnt1;
    logic             acc0;
    logic             acc1;
    logic             burst_end;

    logic             beat_vld;
    master_id_t       beat_id;
    logic [XLEN-1:0]  beat_addr;
    logic [XLEN-1:0]  beat_qin;
    logic [2:0]       beat_we;

    logic             rd_push;
    logic             m0_rvalid;
    logic             m1_rvalid;
    logic [XLEN-1:0]  m0_rdata;
    logic [XLEN-1:0]  m1_rdata;

    assign acc0      = gnt0 & bus.m0_req;
    assign acc1      = gnt1 & bus.m1_req;
    assign burst_end = (beat_cnt == CNT_LAST);

    // Next owner: tie-break on last_owner, hand over on release or on an expired burst.
    // Under fixed priority M0 wins every tie and is never pre-empted.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (bus.m0_req && (FIXED_PRIO || !bus.m1_req || last_owner == LB_M1)) begin
                    state_nxt = ST_OWN0;
                end else if (bus.m1_req) begin
                    state_nxt = ST_OWN1;
                end
            end
            ST_OWN0: begin
                if (!bus.m0_req) begin
                    state_nxt = bus.m1_req ? ST_OWN1 : ST_IDLE;
                end else if (!FIXED_PRIO && burst_end && bus.m1_req) begin
                    state_nxt = ST_OWN1;
                end
            end
            ST_OWN1: begin
                if (!bus.m1_req) begin
                    state_nxt = bus.m0_req ? ST_OWN0 : ST_IDLE;
                end else if (burst_end && bus.m0_req) begin
                    state_nxt = ST_OWN0;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Ownership FSM with registered grants, burst counter and round-robin memory.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            gnt0       <= 1'b0;
            gnt1       <= 1'b0;
            beat_cnt   <= '0;
            last_owner <= LB_M1;
        end else begin
            state <= state_nxt;
            gnt0  <= (state_nxt == ST_OWN0);
            gnt1  <= (state_nxt == ST_OWN1);
            if (state_nxt != state) begin
                beat_cnt <= '0;
                if (state_nxt == ST_OWN0) begin
                    last_owner <= LB_M0;
                end else if (state_nxt == ST_OWN1) begin
                    last_owner <= LB_M1;
                end
            end else if ((acc0 || acc1) && !burst_end) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
        end
    end

    // Drive the bus only for an accepted beat so a stray we can never reach the RAM.
    always_comb begin
        beat_vld  = acc0 || acc1;
        beat_id   = LB_M0;
        beat_addr = '0;
        beat_qin  = '0;
        beat_we   = LB_WE_READ;
        if (acc0) begin
            beat_addr = bus.m0_addr;
            beat_qin  = bus.m0_qin;
            beat_we   = bus.m0_we;
        end else if (acc1) begin
            beat_id   = LB_M1;
            beat_addr = bus.m1_addr;
            beat_qin  = bus.m1_qin;
            beat_we   = bus.m1_we;
        end
    end

    assign rd_push = beat_vld && (beat_we == LB_WE_READ);

    localbus_arbiter_rd_tracker #(
        .XLEN       (XLEN),
        .RD_LATENCY (RD_LATENCY)
    ) u_rd_tracker (
        .clk       (clk),
        .rst       (rst),
        .push_vld  (rd_push),
        .push_id   (beat_id),
        .lb_qout   (bus.lb_qout),
        .m0_rvalid (m0_rvalid),
        .m0_rdata  (m0_rdata),
        .m1_rvalid (m1_rvalid),
        .m1_rdata  (m1_rdata)
    );

    assign bus.m0_gnt    = gnt0;
    assign bus.m1_gnt    = gnt1;
    assign bus.m0_rvalid = m0_rvalid;
    assign bus.m0_rdata  = m0_rdata;
    assign bus.m1_rvalid = m1_rvalid;
    assign bus.m1_rdata  = m1_rdata;
    assign bus.lb_addr   = beat_addr;
    assign bus.lb_qin    = beat_qin;
    assign bus.lb_we     = beat_we;

endmodule

// File: tb/tb_localbus_arbiter.sv
// Directed bench for localbus_arbiter with a read-return scoreboard and a small synchronous RAM.
// Latency: RAM returns lb_qout one cycle after the address.
// Backpressure: each bench master holds req with its head transaction until granted.
module tb_localbus_arbiter;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [2:0]  we;
    } txn_t;

    typedef struct {
        int          id;
        logic [31:0] data;
    } rd_exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    txn_t    q0[$];
    txn_t    q1[$];
    rd_exp_t sb[$];
    int      log_id[$];
    int      log_cyc[$];
    logic [31:0] ram [256];

    localbus_arbiter_if #(.XLEN(32)) bus ();

    localbus_arbiter #(
        .XLEN       (32),
        .MAX_BURST  (8),
        .RD_LATENCY (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Synchronous RAM standing in for localbus: read-before-write, one cycle read latency.
    always @(posedge clk) begin
        bus.lb_qout <= ram[bus.lb_addr[9:2]];
        if (bus.lb_we != 3'b000) ram[bus.lb_addr[9:2]] <= bus.lb_qin;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Read-return monitor: every rvalid must match the oldest expected read.
    always @(negedge clk) begin
        rd_exp_t e;
        if (!rst) begin
            if (bus.m0_rvalid || bus.m1_rvalid) begin
                if (sb.size() == 0) begin
                    check("rd_unexpected", 64'({bus.m1_rvalid, bus.m0_rvalid}), 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("rd_id", 64'({bus.m1_rvalid, bus.m0_rvalid}), (e.id == 1) ? 64'd2 : 64'd1);
                    check("rd_data", 64'((e.id == 1) ? bus.m1_rdata : bus.m0_rdata), 64'(e.data));
                end
            end else begin
                check("rdata_idle", 64'({bus.m1_rdata, bus.m0_rdata}), 64'd0);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic drive();
        bus.m0_req  = (q0.size() != 0);
        bus.m0_addr = (q0.size() != 0) ? q0[0].addr : 32'h0;
        bus.m0_qin  = (q0.size() != 0) ? q0[0].data : 32'h0;
        bus.m0_we   = (q0.size() != 0) ? q0[0].we   : 3'b000;
        bus.m1_req  = (q1.size() != 0);
        bus.m1_addr = (q1.size() != 0) ? q1[0].addr : 32'h0;
        bus.m1_qin  = (q1.size() != 0) ? q1[0].data : 32'h0;
        bus.m1_we   = (q1.size() != 0) ? q1[0].we   : 3'b000;
    endtask

    task automatic beat_check(input int id, input txn_t t);
        rd_exp_t e;
        check("lb_addr", 64'(bus.lb_addr), 64'(t.addr));
        check("lb_qin",  64'(bus.lb_qin),  64'(t.data));
        check("lb_we",   64'(bus.lb_we),   64'(t.we));
        if (t.we == 3'b000) begin
            e.id   = id;
            e.data = ram[t.addr[9:2]];
            sb.push_back(e);
        end
        log_id.push_back(id);
        log_cyc.push_back(cyc);
    endtask

    // One bus cycle: present queue heads, then check whatever beat the bus carries.
    task automatic run_cycle();
        @(posedge clk);
        #1;
        cyc++;
        drive();
        #1;
        check("gnt_onehot", 64'(bus.m0_gnt & bus.m1_gnt), 64'd0);
        if (bus.m0_req && bus.m0_gnt) begin
            beat_check(0, q0[0]);
            q0.delete(0);
        end else if (bus.m1_req && bus.m1_gnt) begin
            beat_check(1, q1[0]);
            q1.delete(0);
        end else begin
            check("lb_we_idle",   64'(bus.lb_we),   64'd0);
            check("lb_addr_idle", 64'(bus.lb_addr), 64'd0);
        end
    endtask

    task automatic run_until_done(input int max_cycles);
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < max_cycles) begin
            run_cycle();
            n++;
        end
        check("drain_timeout", 64'(q0.size() + q1.size()), 64'd0);
        repeat (3) run_cycle();
    endtask

    task automatic do_reset(input int n);
        @(posedge clk);
        #1;
        rst = 1'b1;
        q0.delete();
        q1.delete();
        sb.delete();
        drive();
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
        log_id.delete();
        log_cyc.delete();
    endtask

    task automatic push_txn(input int id, input logic [31:0] a, input logic [31:0] d, input logic [2:0] we);
        txn_t t;
        t.addr = a;
        t.data = d;
        t.we   = we;
        if (id == 0) q0.push_back(t);
        else         q1.push_back(t);
    endtask

    task automatic check_runs(input string tag, input int exp_id[], input int exp_len[]);
        int run_id[$];
        int run_len[$];
        for (int i = 0; i < log_id.size(); i++) begin
            if (run_id.size() == 0 || run_id[run_id.size()-1] != log_id[i]) begin
                run_id.push_back(log_id[i]);
                run_len.push_back(1);
            end else begin
                run_len[run_len.size()-1] += 1;
            end
        end
        check({tag, "_nruns"}, 64'(run_id.size()), 64'(exp_id.size()));
        for (int i = 0; i < exp_id.size() && i < run_id.size(); i++) begin
            check({tag, "_owner"}, 64'(run_id[i]),  64'(exp_id[i]));
            check({tag, "_len"},   64'(run_len[i]), 64'(exp_len[i]));
        end
    endtask

    initial begin
        int exp3_id[]  = '{0, 1, 0, 1, 0};
        int exp3_len[] = '{8, 8, 8, 4, 4};

        // 1: reset held 3 cycles with both masters requesting.
        bus.m0_req = 1'b1; bus.m0_addr = 32'h100; bus.m0_qin = 32'h55; bus.m0_we = 3'b111;
        bus.m1_req = 1'b1; bus.m1_addr = 32'h104; bus.m1_qin = 32'h66; bus.m1_we = 3'b111;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #2;
            check("rst_gnt",    64'({bus.m1_gnt, bus.m0_gnt}), 64'd0);
            check("rst_lb_we",  64'(bus.lb_we), 64'd0);
            check("rst_rvalid", 64'({bus.m1_rvalid, bus.m0_rvalid}), 64'd0);
        end
        rst = 1'b0;
        #1;
        check("post_rst_idle", 64'({bus.m1_gnt, bus.m0_gnt}), 64'd0);
        @(posedge clk);
        #2;
        check("first_tie_gnt", 64'({bus.m1_gnt, bus.m0_gnt}), 64'd1);
        check("first_tie_we",  64'(bus.lb_we), 64'd7);

        // 2: single write of 0xDEADBEEF then read back from 0x10 by M0.
        do_reset(1);
        push_txn(0, 32'h10, 32'hDEADBEEF, 3'b111);
        run_until_done(10);
        push_txn(0, 32'h10, 32'h0, 3'b000);
        run_cycle();
        check("rd_grant_latency", 64'(bus.m0_gnt), 64'd0);
        run_cycle();
        check("rd_beat_taken", 64'(q0.size()), 64'd0);
        run_cycle();
        check("single_m0_rvalid", 64'(bus.m0_rvalid), 64'd1);
        check("single_m0_rdata",  64'(bus.m0_rdata),  64'hDEADBEEF);
        check("single_m1_rvalid", 64'(bus.m1_rvalid), 64'd0);
        repeat (2) run_cycle();

        // 3: burst limit with both masters saturated.
        do_reset(1);
        for (int i = 0; i < 20; i++) push_txn(0, 32'h100 + 32'(4*i), 32'hA000_0000 + 32'(i), 3'b111);
        for (int i = 0; i < 12; i++) push_txn(1, 32'h200 + 32'(4*i), 32'hB000_0000 + 32'(i), 3'b111);
        run_until_done(100);
        check_runs("burst", exp3_id, exp3_len);
        if (log_cyc.size() == 32) begin
            check("burst_no_bubble", 64'(log_cyc[27] - log_cyc[0]), 64'd27);
            check("release_gap",     64'(log_cyc[28] - log_cyc[27]), 64'd2);
        end

        // 4: M0's last beat is a read; M1 writes in the very next cycle.
        do_reset(1);
        for (int i = 0; i < 7; i++) push_txn(0, 32'h300 + 32'(4*i), 32'hC000_0000 + 32'(i), 3'b111);
        push_txn(0, 32'h10, 32'h0, 3'b000);
        push_txn(1, 32'h20, 32'h1234_5678, 3'b111);
        push_txn(1, 32'h20, 32'h0, 3'b000);
        run_until_done(40);
        check("handover_nbeats", 64'(log_id.size()), 64'd10);
        if (log_id.size() == 10) begin
            check("handover_owner", 64'(log_id[8]), 64'd1);
            check("handover_gap",   64'(log_cyc[8] - log_cyc[7]), 64'd1);
        end

        // 5: reset during an M1 read burst with reads in flight.
        do_reset(1);
        for (int i = 0; i < 6; i++) push_txn(1, 32'h300 + 32'(4*i), 32'h0, 3'b000);
        repeat (4) run_cycle();
        @(posedge clk);
        #1;
        rst = 1'b1;
        q0.delete();
        q1.delete();
        sb.delete();
        push_txn(0, 32'h40, 32'h4040, 3'b111);
        push_txn(1, 32'h44, 32'h4444, 3'b111);
        drive();
        @(posedge clk);
        #1;
        rst = 1'b0;
        log_id.delete();
        log_cyc.delete();
        #1;
        check("midrst_rvalid", 64'({bus.m1_rvalid, bus.m0_rvalid}), 64'd0);
        check("midrst_gnt",    64'({bus.m1_gnt, bus.m0_gnt}), 64'd0);
        run_until_done(20);
        check("midrst_nbeats", 64'(log_id.size()), 64'd2);
        if (log_id.size() == 2) check("midrst_tie_owner", 64'(log_id[0]), 64'd0);

`ifdef LOCALBUS_ARB_FIXED_PRIO_EN
        // 6: fixed priority, M0 never pre-empted, M1 pre-empted after a full burst.
        begin
            int exp6_id[]  = '{0, 1, 0, 1};
            int exp6_len[] = '{30, 8, 5, 12};
            bit injected = 1'b0;
            int n = 0;
            do_reset(1);
            for (int i = 0; i < 30; i++) push_txn(0, 32'h100 + 32'(4*i), 32'hD000_0000 + 32'(i), 3'b111);
            for (int i = 0; i < 20; i++) push_txn(1, 32'h200 + 32'(4*i), 32'hE000_0000 + 32'(i), 3'b111);
            while ((q0.size() != 0 || q1.size() != 0) && n < 200) begin
                run_cycle();
                n++;
                if (!injected && log_id.size() == 32) begin
                    for (int i = 0; i < 5; i++) push_txn(0, 32'h380 + 32'(4*i), 32'hF000_0000 + 32'(i), 3'b111);
                    injected = 1'b1;
                end
            end
            check("prio_timeout", 64'(q0.size() + q1.size()), 64'd0);
            repeat (3) run_cycle();
            check_runs("prio", exp6_id, exp6_len);
        end
`endif

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
